// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and an async-read memory (slave).
interface if_stage_if #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32
);
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;

  modport master (output imem_addr, input imem_data);
  modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, stall/redirect handling
// and a saturating stall-cycle counter.
module if_stage #(
  parameter int unsigned      PC_W     = 32,
  parameter int unsigned      INSTR_W  = 32,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter int unsigned      CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hazard_detected,
  input  logic                redirect_en,
  input  logic [PC_W-1:0]     redirect_pc,
  if_stage_if.master          imem,
  output logic [PC_W-1:0]     IF_ID_pc4,
  output logic [INSTR_W-1:0]  IF_ID_instr,
  output logic                IF_ID_valid,
  output logic [CNT_W-1:0]    stall_count
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    pc4_q, pc4_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [PC_W-1:0]    pc_plus4;

  assign pc_plus4 = pc_q + PC_W'(4);

  // Redirect outranks stall: a taken branch squashes the fetch even while frozen.
  always_comb begin
    pc_d        = pc_q;
    pc4_d       = pc4_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    if (redirect_en) begin
      pc_d    = redirect_pc & ~PC_W'(3);
      pc4_d   = '0;
      instr_d = '0;
      valid_d = 1'b0;
    end else if (hazard_detected) begin
      if (stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end else begin
      pc_d    = pc_plus4;
      pc4_d   = pc_plus4;
      instr_d = imem.imem_data;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      pc4_q       <= '0;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      pc4_q       <= pc4_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign imem.imem_addr = pc_q;
  assign IF_ID_pc4      = pc4_q;
  assign IF_ID_instr    = instr_q;
  assign IF_ID_valid    = valid_q;
  assign stall_count    = stall_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, stall, redirect, saturation, wrap.
module tb_if_stage;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 3;

  localparam logic [31:0] INSTR_A = 32'hAAAA_0000;
  localparam logic [31:0] INSTR_B = 32'hBBBB_0004;
  localparam logic [31:0] INSTR_C = 32'hCCCC_0008;

  logic              clk = 1'b0;
  logic              rst;
  logic              hazard_detected;
  logic              redirect_en;
  logic [PC_W-1:0]   redirect_pc;
  logic [PC_W-1:0]   IF_ID_pc4;
  logic [INSTR_W-1:0] IF_ID_instr;
  logic              IF_ID_valid;
  logic [CNT_W-1:0]  stall_count;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  if_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  if_stage #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .RESET_PC(32'h0000_0100),
    .CNT_W   (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .hazard_detected(hazard_detected),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .imem           (bus.master),
    .IF_ID_pc4      (IF_ID_pc4),
    .IF_ID_instr    (IF_ID_instr),
    .IF_ID_valid    (IF_ID_valid),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  // Async-read memory: three fixed words at 0/4/8, address-tagged pattern elsewhere.
  always_comb begin
    case (bus.imem_addr)
      32'h0:   bus.imem_data = INSTR_A;
      32'h4:   bus.imem_data = INSTR_B;
      32'h8:   bus.imem_data = INSTR_C;
      default: bus.imem_data = bus.imem_addr ^ 32'hDEAD_0000;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_if(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                          input logic [31:0] instr, input logic valid, input logic [31:0] cnt);
    check({tag, ".pc"},    bus.imem_addr, pc);
    check({tag, ".pc4"},   IF_ID_pc4, pc4);
    check({tag, ".instr"}, IF_ID_instr, instr);
    check({tag, ".valid"}, 32'(IF_ID_valid), 32'(valid));
    check({tag, ".cnt"},   32'(stall_count), cnt);
  endtask

  initial begin
    rst = 1'b1;
    hazard_detected = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    #2;
    check_if("reset", 32'h100, 32'h0, 32'h0, 1'b0, 0);
    rst = 1'b0;

    step();
    check_if("idle1", 32'h104, 32'h104, 32'hDEAD_0100, 1'b1, 0);
    step();
    step();
    check_if("idle3", 32'h10C, 32'h10C, 32'hDEAD_0108, 1'b1, 0);

    redirect_en = 1'b1; redirect_pc = 32'h0;
    step();
    check_if("redir0", 32'h0, 32'h0, 32'h0, 1'b0, 0);
    redirect_en = 1'b0;
    step();
    check_if("fetchA", 32'h4, 32'h4, INSTR_A, 1'b1, 0);
    step();
    check_if("fetchB", 32'h8, 32'h8, INSTR_B, 1'b1, 0);

    hazard_detected = 1'b1;
    step();
    check_if("stall1", 32'h8, 32'h8, INSTR_B, 1'b1, 1);
    step();
    check_if("stall2", 32'h8, 32'h8, INSTR_B, 1'b1, 2);
    hazard_detected = 1'b0;
    step();
    check_if("fetchC", 32'hC, 32'hC, INSTR_C, 1'b1, 2);

    redirect_en = 1'b1; redirect_pc = 32'h40; hazard_detected = 1'b1;
    step();
    check_if("redir_haz", 32'h40, 32'h0, 32'h0, 1'b0, 2);
    hazard_detected = 1'b0; redirect_pc = 32'h83;
    step();
    check_if("redir_b2b", 32'h80, 32'h0, 32'h0, 1'b0, 2);
    redirect_pc = 32'h43;
    step();
    check_if("redir_align", 32'h40, 32'h0, 32'h0, 1'b0, 2);
    redirect_en = 1'b0;
    step();
    check_if("after_redir", 32'h44, 32'h44, 32'hDEAD_0040, 1'b1, 2);

    hazard_detected = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("sat%0d.cnt", i), 32'(stall_count), (2 + i > 7) ? 32'd7 : 32'(2 + i));
      check($sformatf("sat%0d.pc", i), bus.imem_addr, 32'h44);
    end
    check_if("sat_end", 32'h44, 32'h44, 32'hDEAD_0040, 1'b1, 7);

    hazard_detected = 1'b0; redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    check_if("top_pc", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 7);
    redirect_en = 1'b0;
    step();
    check_if("wrap", 32'h0, 32'h0, 32'h2152_FFFC, 1'b1, 7);

    hazard_detected = 1'b1;
    step();
    check_if("pre_rst_stall", 32'h0, 32'h0, 32'h2152_FFFC, 1'b1, 7);
    #2;
    rst = 1'b1;
    #1;
    check_if("async_rst", 32'h100, 32'h0, 32'h0, 1'b0, 0);
    hazard_detected = 1'b0;
    #2;
    rst = 1'b0;
    step();
    check_if("post_rst", 32'h104, 32'h104, 32'hDEAD_0100, 1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
